// File: rtl/mhrd_cpu_pkg.sv
// mhrd_cpu_pkg: shared opcodes, instruction field positions and word types for the MHRD CPU
package mhrd_cpu_pkg;
  localparam int XLEN = 16;
  localparam int NREGS = 4;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 10;
  localparam int RS_HI = 9;
  localparam int RS_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [$clog2(NREGS)-1:0] reg_idx_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LDI,
    OP_LD, OP_ST, OP_JR, OP_JZ, OP_JMP, OP_RD, OP_RE, OP_RF
  } op_t;
  function automatic word_t sext8(input logic [7:0] v);
    return {{(XLEN-8){v[7]}}, v};
  endfunction
endpackage

// File: rtl/mhrd_cpu_if.sv
// mhrd_cpu_if: instruction ROM and data RAM bus between the CPU (master) and memories (slave)
interface mhrd_cpu_if;
  import mhrd_cpu_pkg::*;
  word_t instr;
  word_t data;
  logic write;
  word_t dataAddr;
  word_t instrAddr;
  word_t result;
  modport master(input instr, data, output write, dataAddr, instrAddr, result);
  modport slave(output instr, data, input write, dataAddr, instrAddr, result);
endinterface

// File: rtl/mhrd_alu.sv
// mhrd_alu: combinational ALU for ADD..LDI; b carries R[rs] or the sign-extended immediate
module mhrd_alu
  import mhrd_cpu_pkg::*;
(
  input  op_t   op,
  input  word_t a,
  input  word_t b,
  output word_t y
);
  always_comb begin
    y = op == OP_ADD ? a + b :
        op == OP_SUB ? a - b :
        op == OP_AND ? a & b :
        op == OP_OR  ? a | b :
        op == OP_XOR ? a ^ b :
        op == OP_NOT ? ~b :
        op == OP_LDI ? b : '0;
  end
endmodule

// File: rtl/mhrd_cpu.sv
// mhrd_cpu: single-cycle 16-bit load/store core; define MHRD_CPU_HALT_EN to make op F a HALT
module mhrd_cpu
  import mhrd_cpu_pkg::*;
#(
  parameter word_t RESET_PC = 16'h0000
) (
  input logic clk,
  input logic reset,
  mhrd_cpu_if.master bus
);
  word_t pc;
  word_t regs [NREGS];
  op_t op;
  reg_idx_t rd, rs;
  logic [7:0] imm;
  word_t a, b, y, npc;
  logic halt, wr_reg;
  assign op = op_t'(bus.instr[OP_HI:OP_LO]);
  assign rd = bus.instr[RD_HI:RD_LO];
  assign rs = bus.instr[RS_HI:RS_LO];
  assign imm = bus.instr[IMM_HI:IMM_LO];
  assign a = regs[rd];
  assign b = op == OP_LDI ? sext8(imm) : regs[rs];
`ifdef MHRD_CPU_HALT_EN
  assign halt = op == OP_RF;
`else
  assign halt = 1'b0;
`endif
  mhrd_alu alu (.op(op), .a(a), .b(b), .y(y));
  always_comb begin
    npc = halt ? pc :
          op == OP_JR ? regs[rs] :
          op == OP_JZ && a == '0 ? pc + sext8(imm) :
          op == OP_JMP ? {8'h00, imm} : pc + 16'd1;
    wr_reg = op inside {[OP_ADD:OP_LD]};
  end
  assign bus.result = op inside {[OP_ADD:OP_LDI]} ? y :
                      op == OP_LD ? bus.data :
                      op == OP_ST ? a : '0;
  assign bus.write = op == OP_ST && !reset;
  assign bus.dataAddr = regs[rs];
  assign bus.instrAddr = pc;
  // result already equals the value to retire for every register-writing op, including LD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      pc <= npc;
      if (wr_reg) regs[rd] <= bus.result;
    end
  end
endmodule

// File: tb/tb_mhrd_cpu.sv
// tb_mhrd_cpu: directed program with hand-computed per-cycle outputs checked by a scoreboard monitor
module tb_mhrd_cpu;
  logic clk = 0;
  logic reset = 1;
  int total = 0;
  int passed = 0;
  typedef struct {
    logic [15:0] ia, da, res;
    logic w;
    string nm;
  } exp_t;
  exp_t q[$];
`ifdef MHRD_CPU_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif
  mhrd_cpu_if ifc();
  mhrd_cpu dut (.clk(clk), .reset(reset), .bus(ifc.slave));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input string f, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s %s: got %h expected %h", nm, f, act, req);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "instrAddr", ifc.instrAddr, e.ia);
      chk(e.nm, "write", {15'd0, ifc.write}, {15'd0, e.w});
      chk(e.nm, "dataAddr", ifc.dataAddr, e.da);
      chk(e.nm, "result", ifc.result, e.res);
    end
  end
  task automatic step(input logic r, input logic [15:0] ins, input logic [15:0] dat,
                      input logic [15:0] ia, input logic w, input logic [15:0] da,
                      input logic [15:0] res, input string nm);
    exp_t e;
    reset = r;
    ifc.instr = ins;
    ifc.data = dat;
    e.ia = ia; e.w = w; e.da = da; e.res = res; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [15:0] p;
    ifc.instr = 16'h0000;
    ifc.data = 16'h0000;
    @(posedge clk);
    #1;
    step(1, 16'h9000, 0, 16'h0000, 0, 16'h0000, 16'h0000, "reset_init");
    step(0, 16'h7405, 0, 16'h0000, 0, 16'h0000, 16'h0005, "ldi_r1_5");
    step(0, 16'h78FD, 0, 16'h0001, 0, 16'h0000, 16'hFFFD, "ldi_r2_m3");
    step(0, 16'h1600, 0, 16'h0002, 0, 16'hFFFD, 16'h0002, "add_r1_r2");
    step(0, 16'h2A00, 0, 16'h0003, 0, 16'hFFFD, 16'h0000, "sub_r2_r2");
    step(0, 16'h7010, 0, 16'h0004, 0, 16'h0000, 16'h0010, "ldi_r0_10");
    step(0, 16'h7C7F, 0, 16'h0005, 0, 16'h0010, 16'h007F, "ldi_r3_7f");
    step(0, 16'h9C00, 0, 16'h0006, 1, 16'h0010, 16'h007F, "st_r3_r0");
    step(0, 16'h8400, 16'h007F, 16'h0007, 0, 16'h0010, 16'h007F, "ld_r1_r0");
    step(0, 16'h9600, 0, 16'h0008, 1, 16'h0000, 16'h007F, "st_r1_r2");
    step(0, 16'hC006, 0, 16'h0009, 0, 16'h0010, 16'h0000, "jmp_06");
    step(0, 16'hB804, 0, 16'h0006, 0, 16'h0010, 16'h0000, "jz_taken");
    step(0, 16'h6B00, 0, 16'h000A, 0, 16'h007F, 16'hFF80, "not_r2_r3");
    step(0, 16'hC006, 0, 16'h000B, 0, 16'h0010, 16'h0000, "jmp_06b");
    step(0, 16'hB804, 0, 16'h0006, 0, 16'h0010, 16'h0000, "jz_not_taken");
    step(0, 16'h3600, 0, 16'h0007, 0, 16'hFF80, 16'h0000, "and_r1_r2");
    step(0, 16'h4700, 0, 16'h0008, 0, 16'h007F, 16'h007F, "or_r1_r3");
    step(0, 16'h5600, 0, 16'h0009, 0, 16'hFF80, 16'hFFFF, "xor_r1_r2");
    step(0, 16'h2000, 0, 16'h000A, 0, 16'h0010, 16'h0000, "sub_r0_r0");
    step(0, 16'hB0FE, 0, 16'h000B, 0, 16'h0000, 16'h0000, "jz_back");
    step(0, 16'hC020, 0, 16'h0009, 0, 16'h0000, 16'h0000, "jmp_20");
    step(0, 16'h7CFF, 0, 16'h0020, 0, 16'h0000, 16'hFFFF, "ldi_r3_m1");
    step(0, 16'hA300, 0, 16'h0021, 0, 16'hFFFF, 16'h0000, "jr_r3");
    step(0, 16'h0000, 0, 16'hFFFF, 0, 16'h0000, 16'h0000, "nop_wrap");
    for (int i = 0; i < 5; i++)
      step(0, 16'hF000, 0, HALT ? 16'h0000 : 16'(i), 0, 16'h0000, 16'h0000, "op_f");
    p = HALT ? 16'h0000 : 16'h0005;
    step(0, 16'hD000, 0, p, 0, 16'h0000, 16'h0000, "op_d");
    step(0, 16'hE000, 0, p + 16'd1, 0, 16'h0000, 16'h0000, "op_e");
    step(0, 16'h9700, 0, p + 16'd2, 1, 16'hFFFF, 16'hFFFF, "st_r1_r3");
    step(1, 16'h9700, 0, 16'h0000, 0, 16'h0000, 16'h0000, "reset_mid");
    step(1, 16'h9F00, 0, 16'h0000, 0, 16'h0000, 16'h0000, "reset_r3");
    step(1, 16'h9B00, 0, 16'h0000, 0, 16'h0000, 16'h0000, "reset_r2");
    step(1, 16'h9000, 0, 16'h0000, 0, 16'h0000, 16'h0000, "reset_r0");
    step(0, 16'h9400, 0, 16'h0000, 1, 16'h0000, 16'h0000, "release_r1");
    step(0, 16'h7405, 0, 16'h0001, 0, 16'h0000, 16'h0005, "after_reset");
    @(negedge clk);
    #1;
    chk("drain", "pending", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
